// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsRAlu, ClsAddi, ClsBeq, ClsBne, ClsJ, ClsJal, ClsJr, ClsLw, ClsSw
  } cls_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluSlt = 3'd3;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] MemToRegAlu = 2'd0;
  localparam logic [1:0] MemToRegMem = 2'd1;
  localparam logic [1:0] MemToRegPc  = 2'd2;

  localparam logic [1:0] AluSrcBReg = 2'd0;
  localparam logic [1:0] AluSrcBImm = 2'd1;

endpackage

// File: rtl/mips_op_classify.sv
// Combinational opcode/funct decoder: instruction class, ALU op and illegal flag.
module mips_op_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o     = ClsNone;
    alu_op_o  = AluAdd;
    illegal_o = 1'b0;
    case (opcode_i)
      OpRtype: begin
        case (funct_i)
          FnAdd, FnAddu: cls_o = ClsRAlu;
          FnSub: begin
            cls_o    = ClsRAlu;
            alu_op_o = AluSub;
          end
          FnSlt: begin
            cls_o    = ClsRAlu;
            alu_op_o = AluSlt;
          end
          FnJr:    cls_o = ClsJr;
          default: illegal_o = 1'b1;
        endcase
      end
      OpAddi, OpAddiu: cls_o = ClsAddi;
      OpBeq: begin
        cls_o    = ClsBeq;
        alu_op_o = AluSub;
      end
      OpBne: begin
        cls_o    = ClsBne;
        alu_op_o = AluSub;
      end
      OpJ:     cls_o = ClsJ;
      OpJal:   cls_o = ClsJal;
      OpLw:    cls_o = ClsLw;
      OpSw:    cls_o = ClsSw;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb over a shared
// memory port, traps on illegal instructions and memory timeouts.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             mem_is_fetch,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       alu_src_b,
  output logic             extend_method,
  output logic [2:0]       alu_cntrl,
  output logic [1:0]       mem_to_reg,
  output logic             branch,
  output logic             inv_zero,
  output logic             jump,
  output logic             jump_reg,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam logic [TO_W-1:0] ToLast = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d, dec_cls;
  logic [2:0]        alu_q, alu_d, dec_alu;
  logic              dec_illegal;
  logic              illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              to_hit, retire;
  logic              unused_instr;

  assign unused_instr = ^instruction[25:6];

  mips_op_classify u_classify (
    .opcode_i  (instruction[31:26]),
    .funct_i   (instruction[5:0]),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu),
    .illegal_o (dec_illegal)
  );

  // Only meaningful in FETCH/MEM, where mem_req is asserted.
  assign to_hit = (TIMEOUT != 0) && !mem_ready && (to_cnt_q == ToLast);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_d     = alu_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (to_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        alu_d = dec_alu;
        if (dec_illegal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls_q)
          ClsRAlu, ClsAddi: state_d = StWb;
          ClsLw, ClsSw:     state_d = StMem;
          default:          state_d = StFetch;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (cls_q == ClsSw) ? StFetch : StWb;
        end else if (to_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StTrap;
    endcase

    retire    = (state_d == StFetch) && (state_q inside {StExec, StMem, StWb});
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (mem_req && !mem_ready) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsNone;
      alu_q     <= AluAdd;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      to_cnt_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_wr        = 1'b0;
    mem_is_fetch  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_wr        = 1'b0;
    reg_dst       = RegDstRt;
    alu_src_b     = AluSrcBReg;
    extend_method = 1'b0;
    alu_cntrl     = AluAdd;
    mem_to_reg    = MemToRegAlu;
    branch        = 1'b0;
    inv_zero      = 1'b0;
    jump          = 1'b0;
    jump_reg      = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
      end
      StExec: begin
        case (cls_q)
          ClsRAlu: alu_cntrl = alu_q;
          ClsAddi, ClsLw, ClsSw: alu_src_b = AluSrcBImm;
          ClsBeq, ClsBne: begin
            alu_cntrl = AluSub;
            branch    = 1'b1;
            inv_zero  = (cls_q == ClsBne);
          end
          ClsJ:    jump = 1'b1;
          ClsJal: begin
            jump       = 1'b1;
            reg_wr     = 1'b1;
            reg_dst    = RegDstRa;
            mem_to_reg = MemToRegPc;
          end
          ClsJr:   jump_reg = 1'b1;
          default: ;
        endcase
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_wr    = (cls_q == ClsSw);
        alu_src_b = AluSrcBImm;
      end
      StWb: begin
        reg_wr     = 1'b1;
        reg_dst    = (cls_q == ClsRAlu) ? RegDstRd : RegDstRt;
        mem_to_reg = (cls_q == ClsLw) ? MemToRegMem : MemToRegAlu;
      end
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control unit (TIMEOUT=4, CNT_W=2).
module tb_mips_multicycle_control;

  localparam int unsigned CntW = 2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr;
    logic       mem_is_fetch;
    logic       ir_write;
    logic       pc_write;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic       ext;
    logic [2:0] alu;
    logic [1:0] m2r;
    logic       branch;
    logic       inv_zero;
    logic       jump;
    logic       jump_reg;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    ctrl_t       exec_c;
    logic        has_mem;
    ctrl_t       mem_c;
    logic        has_wb;
    ctrl_t       wb_c;
  } vec_t;

  logic            clk, rst_n, mem_ready;
  logic [31:0]     instruction;
  logic            mem_req, mem_wr, mem_is_fetch, ir_write, pc_write, reg_wr;
  logic [1:0]      reg_dst, alu_src_b, mem_to_reg;
  logic            extend_method, branch, inv_zero, jump, jump_reg, illegal, bus_error;
  logic [2:0]      alu_cntrl;
  logic [CntW-1:0] retired;
  ctrl_t           act;

  mips_multicycle_control #(
    .TIMEOUT (4),
    .CNT_W   (CntW),
    .TO_W    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_is_fetch  (mem_is_fetch),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_wr        (reg_wr),
    .reg_dst       (reg_dst),
    .alu_src_b     (alu_src_b),
    .extend_method (extend_method),
    .alu_cntrl     (alu_cntrl),
    .mem_to_reg    (mem_to_reg),
    .branch        (branch),
    .inv_zero      (inv_zero),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .illegal       (illegal),
    .bus_error     (bus_error),
    .retired       (retired)
  );

  assign act = {mem_req, mem_wr, mem_is_fetch, ir_write, pc_write, reg_wr, reg_dst, alu_src_b,
                extend_method, alu_cntrl, mem_to_reg, branch, inv_zero, jump, jump_reg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [CntW-1:0] exp_ret;
  ctrl_t           c_zero, c_fetch, c_fwait, m_lw, w_lw, e_imm, e_add;
  vec_t            vecs[13];

  function automatic void chk_ctrl(input string nm, input ctrl_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ctrl %h, want %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input ctrl_t e, input logic hm,
                              input ctrl_t m, input logic hw, input ctrl_t w);
    mk.instr   = i;
    mk.exec_c  = e;
    mk.has_mem = hm;
    mk.mem_c   = m;
    mk.has_wb  = hw;
    mk.wb_c    = w;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ready(input logic r);
    mem_ready = r;
    #1;
  endtask

  // Leaves the bench 2 time units into the first FETCH cycle.
  task automatic reset_dut();
    rst_n       = 1'b0;
    mem_ready   = 1'b0;
    instruction = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_ctrl("reset ctrl", c_zero);
    chk_val("reset retired", 32'(retired), 0);
    chk_val("reset flags", {30'd0, illegal, bus_error}, 0);
    rst_n = 1'b1;
    #1;
    chk_ctrl("idle ctrl", c_zero);
    exp_ret = '0;
    next_cycle();
  endtask

  // Runs one instruction with mem_ready=1 on every request; starts and ends in FETCH.
  task automatic run_vec(input vec_t v, input string nm);
    instruction = v.instr;
    set_ready(1'b1);
    chk_ctrl({nm, " fetch"}, c_fetch);
    next_cycle();
    set_ready(1'b0);
    chk_ctrl({nm, " decode"}, c_zero);
    next_cycle();
    chk_ctrl({nm, " exec"}, v.exec_c);
    if (v.has_mem) begin
      next_cycle();
      set_ready(1'b1);
      chk_ctrl({nm, " mem"}, v.mem_c);
    end
    if (v.has_wb) begin
      next_cycle();
      set_ready(1'b0);
      chk_ctrl({nm, " wb"}, v.wb_c);
    end
    next_cycle();
    exp_ret = exp_ret + 1'b1;
    chk_val({nm, " retired"}, 32'(retired), 32'(exp_ret));
  endtask

  task automatic trap_illegal(input logic [31:0] instr, input string nm);
    reset_dut();
    instruction = instr;
    set_ready(1'b1);
    chk_ctrl({nm, " fetch"}, c_fetch);
    next_cycle();
    set_ready(1'b0);
    chk_ctrl({nm, " decode"}, c_zero);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_ready(i[0]);
      chk_ctrl({nm, " trap ctrl"}, c_zero);
      chk_val({nm, " trap illegal"}, {31'd0, illegal}, 1);
    end
    rst_n = 1'b0;
    #1;
    chk_val({nm, " illegal after rst"}, {31'd0, illegal}, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_ready   = 1'b0;
    instruction = '0;

    c_zero  = '0;
    c_fetch = '0; c_fetch.mem_req = 1; c_fetch.mem_is_fetch = 1;
    c_fwait = c_fetch;
    c_fetch.ir_write = 1; c_fetch.pc_write = 1;
    e_add = '0;
    e_imm = '0; e_imm.alu_src_b = 2'd1;
    m_lw  = e_imm; m_lw.mem_req = 1;
    w_lw  = '0; w_lw.reg_wr = 1; w_lw.m2r = 2'd1;

    begin
      ctrl_t e_sub, e_slt, e_beq, e_bne, e_j, e_jal, e_jr, m_sw, w_rd, w_rt;
      e_sub = '0; e_sub.alu = 3'd1;
      e_slt = '0; e_slt.alu = 3'd3;
      e_beq = e_sub; e_beq.branch = 1;
      e_bne = e_beq; e_bne.inv_zero = 1;
      e_j   = '0; e_j.jump = 1;
      e_jal = e_j; e_jal.reg_wr = 1; e_jal.reg_dst = 2'd2; e_jal.m2r = 2'd2;
      e_jr  = '0; e_jr.jump_reg = 1;
      m_sw  = m_lw; m_sw.mem_wr = 1;
      w_rt  = '0; w_rt.reg_wr = 1;
      w_rd  = w_rt; w_rd.reg_dst = 2'd1;
      vecs[0]  = mk(32'h2047000F, e_imm, 0, c_zero, 1, w_rt);  // addi
      vecs[1]  = mk(32'h2447000F, e_imm, 0, c_zero, 1, w_rt);  // addiu
      vecs[2]  = mk(32'h00473021, e_add, 0, c_zero, 1, w_rd);  // addu
      vecs[3]  = mk(32'h00473022, e_sub, 0, c_zero, 1, w_rd);  // sub
      vecs[4]  = mk(32'h0047302A, e_slt, 0, c_zero, 1, w_rd);  // slt
      vecs[5]  = mk(32'h10470003, e_beq, 0, c_zero, 0, c_zero);
      vecs[6]  = mk(32'h14470003, e_bne, 0, c_zero, 0, c_zero);
      vecs[7]  = mk(32'h08000010, e_j,   0, c_zero, 0, c_zero);
      vecs[8]  = mk(32'h0C000010, e_jal, 0, c_zero, 0, c_zero);
      vecs[9]  = mk(32'h03E00008, e_jr,  0, c_zero, 0, c_zero);
      vecs[10] = mk(32'h8C470004, e_imm, 1, m_lw,   1, w_lw);
      vecs[11] = mk(32'hAC470004, e_imm, 1, m_sw,   0, c_zero);
      vecs[12] = mk(32'h00473020, e_add, 0, c_zero, 1, w_rd);  // add
    end

    reset_dut();
    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // lw with memory answering on the 4th MEM cycle.
    reset_dut();
    instruction = 32'h8C470004;
    set_ready(1'b1);
    chk_ctrl("lwdly fetch", c_fetch);
    next_cycle();
    set_ready(1'b0);
    next_cycle();
    chk_ctrl("lwdly exec", e_imm);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      set_ready(k == 3);
      chk_ctrl($sformatf("lwdly mem%0d", k), m_lw);
      next_cycle();
    end
    set_ready(1'b0);
    chk_ctrl("lwdly wb", w_lw);
    next_cycle();
    chk_val("lwdly retired", 32'(retired), 1);

    trap_illegal(32'h3C470001, "ill_op");
    trap_illegal(32'h0047303F, "ill_fn");

    // Fetch stalls past the timeout.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      set_ready(1'b0);
      chk_ctrl($sformatf("to wait%0d", i), c_fwait);
      next_cycle();
    end
    chk_ctrl("to trap ctrl", c_zero);
    chk_val("to bus_error", {31'd0, bus_error}, 1);
    chk_val("to illegal", {31'd0, illegal}, 0);
    set_ready(1'b1);
    next_cycle();
    chk_ctrl("to trap hold", c_zero);

    // mem_ready on the 4th wait cycle beats the timeout.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      set_ready(1'b0);
      next_cycle();
    end
    instruction = 32'h00473021;
    set_ready(1'b1);
    chk_ctrl("to race fetch", c_fetch);
    next_cycle();
    set_ready(1'b0);
    chk_val("to race bus_error", {31'd0, bus_error}, 0);
    chk_ctrl("to race decode", c_zero);
    next_cycle();
    chk_ctrl("to race exec", e_add);

    // Retired counter wraps at 2 bits.
    reset_dut();
    for (int i = 0; i < 5; i++) run_vec(vecs[2], $sformatf("wrap%0d", i));

    // Reset during a stalled MEM access.
    reset_dut();
    run_vec(vecs[2], "pre");
    instruction = 32'h8C470004;
    set_ready(1'b1);
    next_cycle();
    set_ready(1'b0);
    next_cycle();
    next_cycle();
    chk_ctrl("abort mem1", m_lw);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk_val("abort mem_req", {31'd0, mem_req}, 0);
    chk_val("abort retired", 32'(retired), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
